gtyp_rx_block_lock: RTL and testbench
=====================================

Name: gtyp_rx_block_lock

Overview:
- Per-lane 64b/66b receive block-lock stage, one instance per GTYP channel (ch0..ch3), sitting directly downstream of the GTYP quad subsystem RX gearbox interface.
- Consumes chN_rxheader_ext / chN_rxheadervalid_ext and produces chN_rxgearboxslip_ext back into the quad.
- Drives block_lock to the PRBS checker, which must ignore data until lock.
- Implements the 802.3 clause-49 style lock/slip FSM, adapted to two 66b blocks per rxusrclk cycle.

Parameters:
SH_WINDOW, 64, valid sync headers required to gain lock, and locked-state window length.
SH_INVALID_MAX, 16, invalid headers within one locked window that cause loss of lock.
SLIP_WAIT, 32, rx_clk cycles headers are ignored after each slip pulse (gearbox settle time).
CNT_W, 16, width of the status counters.

Ports:
rx_clk  in  1  lane rxusrclk; all logic is in this domain.
rx_rst_n  in  1  asynchronous assert, active-low reset.
cfg_enable  in  1  0 forces SEARCH, suppresses slips, clears block_lock.
rxheader  in  6  [1:0] = header of block 0, [4:3] = header of block 1; bits 2 and 5 are ignored.
rxheadervalid  in  2  bit i qualifies the header of block i.
rxgearboxslip  out  1  one-cycle slip request to the GT.
block_lock  out  1  lane is block-locked.
slip_cnt  out  CNT_W  slips issued, saturating.
lock_loss_cnt  out  CNT_W  LOCKED->SLIP transitions, saturating.
clr_cnt  in  1  synchronous clear of slip_cnt and lock_loss_cnt.

Behaviour:
- Header validity: a header is valid when it is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid. Only headers whose valid bit is set are counted.
- Per-cycle counts: v = number of qualified headers (0..2); e = number of qualified invalid headers (0..2).
- Reset values: all outputs 0; state SEARCH; sh_cnt, inv_cnt and wait_cnt 0.
- SEARCH (block_lock=0):
  - If e>0: sh_cnt<=0, go to SLIP.
  - Else if sh_cnt+v >= SH_WINDOW: go to LOCKED, clear sh_cnt and inv_cnt.
  - Else: sh_cnt += v.
- LOCKED (block_lock=1):
  - If inv_cnt+e >= SH_INVALID_MAX: go to SLIP, block_lock<=0, lock_loss_cnt++. This check takes priority over window end in the same cycle.
  - Else if sh_cnt+v >= SH_WINDOW: clear sh_cnt and inv_cnt; the overflow header is dropped, not carried.
  - Else: sh_cnt += v, inv_cnt += e.
- SLIP: rxgearboxslip=1 for exactly this one cycle, slip_cnt++, wait_cnt<=0, then go to SLIP_WAIT.
- SLIP_WAIT: headers are ignored. wait_cnt increments each cycle; after SLIP_WAIT cycles go to SEARCH with counters cleared.
- Output timing: all outputs are registered. block_lock rises one cycle after the cycle delivering the SH_WINDOW-th consecutive valid header. rxgearboxslip is asserted the cycle after the invalid header is seen.
- Slip period: with constant invalid headers, rxgearboxslip pulses every SLIP_WAIT+2 = 34 cycles.
- cfg_enable=0: state is forced to SEARCH with counters and block_lock cleared, and no slips are issued. A slip pulse in progress completes its single cycle only.
- Counter saturation: slip_cnt and lock_loss_cnt hold at 2^CNT_W-1.
- clr_cnt vs increment: if clr_cnt and an increment occur in the same cycle, clr_cnt wins and the result is 0.
- Asynchronous reset mid-operation: reset returns everything to reset values immediately. rxgearboxslip must drop in the same reset assertion, with no residual pulse after release.

Test Plan:
1. Headers 2'b01 on both blocks, valid=2'b11, every cycle after reset -> block_lock=1 on cycle 33 after release; rxgearboxslip never asserted; slip_cnt=0.
2. Headers 2'b00, valid=2'b11, constant -> first slip pulse on cycle 2, then pulses every 34 cycles; slip_cnt=3 after 70 cycles; block_lock stays 0.
3. Locked lane, inject 15 invalid headers spread within one 64-header window -> block_lock stays 1. Inject 16 -> block_lock=0 next cycle, lock_loss_cnt=1, slip pulse same cycle.
4. Alternating valid=2'b01 / 2'b10 with good headers -> lock after 64 cycles. Valid=2'b00 cycles -> counters frozen, no lock change.
5. Assert rx_rst_n low during SLIP_WAIT at wait_cnt=10 -> all outputs 0 immediately. After release, good headers give lock 32 cycles later.
6. slip_cnt preloaded to 0xFFFF with invalid headers -> holds 0xFFFF. clr_cnt pulsed on a slip cycle -> slip_cnt=0.

Source files
------------

// File: rtl/gtyp_rx_block_lock_if.sv
// gtyp_rx_block_lock_if
//   Per-lane RX gearbox link between the GTYP quad and the block-lock stage.
//   rxheader      : [1:0] header of block 0, [4:3] header of block 1 (bits 2/5 unused)
//   rxheadervalid : bit i qualifies the header of block i
//   rxgearboxslip : one-cycle slip request back to the GT
//   block_lock    : lane is block-locked (consumed by the PRBS checker)
//   master = GT/quad side, slave = block-lock stage.
interface gtyp_rx_block_lock_if;
    logic [5:0] rxheader;
    logic [1:0] rxheadervalid;
    logic       rxgearboxslip;
    logic       block_lock;

    modport master (
        output rxheader,
        output rxheadervalid,
        input  rxgearboxslip,
        input  block_lock
    );

    modport slave (
        input  rxheader,
        input  rxheadervalid,
        output rxgearboxslip,
        output block_lock
    );
endinterface

// File: rtl/gtyp_rx_block_lock.sv
// gtyp_rx_block_lock
//   64b/66b block-lock / gearbox-slip FSM for one GTYP lane, two 66b headers
//   per rx_clk cycle.
//   Ports:
//     rx_clk, rx_rst_n : lane clock, async active-low reset
//     cfg_enable       : 0 holds the lane in SEARCH, no slips, no lock
//     gt               : header/valid in, slip/block_lock out (slave modport)
//     slip_cnt         : slips issued, saturating
//     lock_loss_cnt    : LOCKED->SLIP transitions, saturating
//     clr_cnt          : synchronous clear of both counters (beats increments)
module gtyp_rx_block_lock #(
    parameter int SH_WINDOW      = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_WAIT      = 32,
    parameter int CNT_W          = 16
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst_n,
    input  logic                   cfg_enable,
    gtyp_rx_block_lock_if.slave    gt,
    output logic [CNT_W-1:0]       slip_cnt,
    output logic [CNT_W-1:0]       lock_loss_cnt,
    input  logic                   clr_cnt
);
    // One spare bit so cnt+2 never wraps before the threshold compare.
    localparam int SH_W  = $clog2(SH_WINDOW + 1) + 1;
    localparam int INV_W = $clog2(SH_INVALID_MAX + 1) + 1;
    localparam int WT_W  = $clog2(SLIP_WAIT + 1) + 1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCKED = 2'd1,
        ST_SLIP   = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [SH_W-1:0]   sh_cnt, sh_nxt, sh_sum;
    logic [INV_W-1:0]  inv_cnt, inv_nxt, inv_sum;
    logic [WT_W-1:0]   wait_cnt, wait_nxt;
    logic [1:0]        hdr0, hdr1;
    logic              q0, q1, bad0, bad1;
    logic [1:0]        v, e;
    logic              slip_q, lock_q;
    logic              slip_inc, loss_inc;

    // Bits 2 and 5 carry no header information.
    logic unused_hdr_bits;
    assign unused_hdr_bits = gt.rxheader[5] ^ gt.rxheader[2];

    assign hdr0 = gt.rxheader[1:0];
    assign hdr1 = gt.rxheader[4:3];
    assign q0   = gt.rxheadervalid[0];
    assign q1   = gt.rxheadervalid[1];
    // 01/10 are legal sync headers; 00/11 are not.
    assign bad0 = q0 & ~(hdr0[1] ^ hdr0[0]);
    assign bad1 = q1 & ~(hdr1[1] ^ hdr1[0]);
    assign v    = {1'b0, q0} + {1'b0, q1};
    assign e    = {1'b0, bad0} + {1'b0, bad1};

    assign sh_sum  = sh_cnt + SH_W'(v);
    assign inv_sum = inv_cnt + INV_W'(e);

    always_comb begin
        state_nxt = state;
        sh_nxt    = sh_cnt;
        inv_nxt   = inv_cnt;
        wait_nxt  = wait_cnt;
        if (!cfg_enable) begin
            state_nxt = ST_SEARCH;
            sh_nxt    = '0;
            inv_nxt   = '0;
            wait_nxt  = '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (e != 2'd0) begin
                        sh_nxt    = '0;
                        state_nxt = ST_SLIP;
                    end else if (sh_sum >= SH_W'(SH_WINDOW)) begin
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                        state_nxt = ST_LOCKED;
                    end else begin
                        sh_nxt = sh_sum;
                    end
                end
                ST_LOCKED: begin
                    // Too many invalid headers beats window end.
                    if (inv_sum >= INV_W'(SH_INVALID_MAX)) begin
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                        state_nxt = ST_SLIP;
                    end else if (sh_sum >= SH_W'(SH_WINDOW)) begin
                        // Window closes; any overflow header is not carried.
                        sh_nxt  = '0;
                        inv_nxt = '0;
                    end else begin
                        sh_nxt  = sh_sum;
                        inv_nxt = inv_sum;
                    end
                end
                ST_SLIP: begin
                    wait_nxt  = '0;
                    state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    // Headers ignored while the gearbox settles.
                    if (wait_cnt == WT_W'(SLIP_WAIT - 1)) begin
                        wait_nxt  = '0;
                        sh_nxt    = '0;
                        inv_nxt   = '0;
                        state_nxt = ST_SEARCH;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end
    end

    // SLIP is only entered from SEARCH/LOCKED, so this fires once per slip.
    assign slip_inc = (state_nxt == ST_SLIP) && (state != ST_SLIP);
    assign loss_inc = (state == ST_LOCKED) && (state_nxt == ST_SLIP);

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            state    <= ST_SEARCH;
            sh_cnt   <= '0;
            inv_cnt  <= '0;
            wait_cnt <= '0;
            slip_q   <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sh_cnt   <= sh_nxt;
            inv_cnt  <= inv_nxt;
            wait_cnt <= wait_nxt;
            // Outputs registered off the next state so they line up with it.
            slip_q   <= (state_nxt == ST_SLIP);
            lock_q   <= (state_nxt == ST_LOCKED);
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            slip_cnt      <= '0;
            lock_loss_cnt <= '0;
        end else if (clr_cnt) begin
            slip_cnt      <= '0;
            lock_loss_cnt <= '0;
        end else begin
            if (slip_inc && (slip_cnt != {CNT_W{1'b1}}))
                slip_cnt <= slip_cnt + 1'b1;
            if (loss_inc && (lock_loss_cnt != {CNT_W{1'b1}}))
                lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end

    assign gt.rxgearboxslip = slip_q;
    assign gt.block_lock    = lock_q;
endmodule

// File: tb/tb_gtyp_rx_block_lock.sv
module tb_gtyp_rx_block_lock;
    localparam int CNT_W = 4;   // small counter so saturation is reachable

    localparam logic [5:0] HDR_GOOD  = 6'b001001; // 01 / 01
    localparam logic [5:0] HDR_GOOD2 = 6'b110110; // 10 / 10, bits 2,5 set
    localparam logic [5:0] HDR_BAD   = 6'b000000; // 00 / 00
    localparam logic [5:0] HDR_B0BAD = 6'b001000; // blk0 00, blk1 01

    logic             rx_clk;
    logic             rx_rst_n;
    logic             cfg_enable;
    logic             clr_cnt;
    logic [CNT_W-1:0] slip_cnt;
    logic [CNT_W-1:0] lock_loss_cnt;
    int               tests;
    int               fails;

    gtyp_rx_block_lock_if gt_if();

    gtyp_rx_block_lock #(.CNT_W(CNT_W)) dut (
        .rx_clk        (rx_clk),
        .rx_rst_n      (rx_rst_n),
        .cfg_enable    (cfg_enable),
        .gt            (gt_if.slave),
        .slip_cnt      (slip_cnt),
        .lock_loss_cnt (lock_loss_cnt),
        .clr_cnt       (clr_cnt)
    );

    initial rx_clk = 1'b0;
    always #5 rx_clk = ~rx_clk;

    // Hold reset two edges, release 1ns after a posedge; next posedge is edge 1.
    task automatic do_reset(input logic [5:0] hdr, input logic [1:0] vld);
        rx_rst_n              = 1'b0;
        cfg_enable            = 1'b1;
        clr_cnt               = 1'b0;
        gt_if.rxheader        = hdr;
        gt_if.rxheadervalid   = vld;
        repeat (2) @(posedge rx_clk);
        #1 rx_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rx_rst_n            = 1'b0;
        cfg_enable          = 1'b1;
        clr_cnt             = 1'b0;
        gt_if.rxheader      = HDR_BAD;
        gt_if.rxheadervalid = 2'b11;
        #3;
        tests++;
        if ({gt_if.rxgearboxslip, gt_if.block_lock, slip_cnt, lock_loss_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got slip=%b lock=%b slip_cnt=%0d loss=%0d, want all 0",
                     gt_if.rxgearboxslip, gt_if.block_lock, slip_cnt, lock_loss_cnt);
        end
    endtask

    task automatic test_lock_good();
        do_reset(HDR_GOOD, 2'b11);
        for (int n = 1; n <= 40; n++) begin
            @(posedge rx_clk); #1;
            if (n == 20) gt_if.rxheader = HDR_GOOD2;
            tests++;
            if (gt_if.block_lock !== (n >= 32) || gt_if.rxgearboxslip !== 1'b0) begin
                fails++;
                $display("FAIL lock_good cyc%0d: lock=%b slip=%b, want lock=%b slip=0",
                         n, gt_if.block_lock, gt_if.rxgearboxslip, n >= 32);
            end
        end
        tests++;
        if (slip_cnt !== 4'd0) begin
            fails++;
            $display("FAIL lock_good_slip_cnt: got %0d want 0", slip_cnt);
        end
    endtask

    task automatic test_slip_period();
        do_reset(HDR_BAD, 2'b11);
        for (int n = 1; n <= 70; n++) begin
            @(posedge rx_clk); #1;
            tests++;
            if (gt_if.rxgearboxslip !== (n == 1 || n == 35 || n == 69) || gt_if.block_lock !== 1'b0) begin
                fails++;
                $display("FAIL slip_period cyc%0d: slip=%b lock=%b", n,
                         gt_if.rxgearboxslip, gt_if.block_lock);
            end
        end
        tests++;
        if (slip_cnt !== 4'd3) begin
            fails++;
            $display("FAIL slip_period_cnt: got %0d want 3", slip_cnt);
        end
    endtask

    task automatic test_invalid_threshold();
        do_reset(HDR_GOOD, 2'b11);
        repeat (32) @(posedge rx_clk);
        #1;
        tests++;
        if (gt_if.block_lock !== 1'b1) begin
            fails++;
            $display("FAIL thr_locked: lock=%b want 1", gt_if.block_lock);
        end
        // Window 1: 15 invalid headers then good ones; window closes at cycle 32.
        gt_if.rxheader = HDR_B0BAD;
        for (int n = 1; n <= 32; n++) begin
            @(posedge rx_clk); #1;
            if (n == 15) gt_if.rxheader = HDR_GOOD;
            tests++;
            if (gt_if.block_lock !== 1'b1 || gt_if.rxgearboxslip !== 1'b0) begin
                fails++;
                $display("FAIL thr_15 cyc%0d: lock=%b slip=%b want 1/0", n,
                         gt_if.block_lock, gt_if.rxgearboxslip);
            end
        end
        // Window 2: 16th invalid header drops lock.
        gt_if.rxheader = HDR_B0BAD;
        for (int n = 1; n <= 16; n++) begin
            @(posedge rx_clk); #1;
            tests++;
            if (gt_if.block_lock !== (n < 16) || gt_if.rxgearboxslip !== (n == 16)) begin
                fails++;
                $display("FAIL thr_16 cyc%0d: lock=%b slip=%b want %b/%b", n,
                         gt_if.block_lock, gt_if.rxgearboxslip, n < 16, n == 16);
            end
        end
        tests++;
        if (lock_loss_cnt !== 4'd1 || slip_cnt !== 4'd1) begin
            fails++;
            $display("FAIL thr_counts: loss=%0d slip_cnt=%0d want 1/1", lock_loss_cnt, slip_cnt);
        end
    endtask

    task automatic test_alt_valid();
        do_reset(HDR_BAD, 2'b00);
        // Unqualified bad headers must be ignored.
        for (int n = 1; n <= 10; n++) begin
            @(posedge rx_clk); #1;
            tests++;
            if (gt_if.rxgearboxslip !== 1'b0 || gt_if.block_lock !== 1'b0) begin
                fails++;
                $display("FAIL alt_frozen cyc%0d: slip=%b lock=%b", n,
                         gt_if.rxgearboxslip, gt_if.block_lock);
            end
        end
        gt_if.rxheader = HDR_GOOD;
        gt_if.rxheadervalid = 2'b01;
        for (int n = 1; n <= 64; n++) begin
            @(posedge rx_clk); #1;
            gt_if.rxheadervalid = ~gt_if.rxheadervalid;
            tests++;
            if (gt_if.block_lock !== (n == 64)) begin
                fails++;
                $display("FAIL alt_lock cyc%0d: lock=%b want %b", n, gt_if.block_lock, n == 64);
            end
        end
        gt_if.rxheader = HDR_BAD;
        gt_if.rxheadervalid = 2'b00;
        for (int n = 1; n <= 20; n++) begin
            @(posedge rx_clk); #1;
            tests++;
            if (gt_if.block_lock !== 1'b1 || gt_if.rxgearboxslip !== 1'b0) begin
                fails++;
                $display("FAIL alt_hold cyc%0d: lock=%b slip=%b want 1/0", n,
                         gt_if.block_lock, gt_if.rxgearboxslip);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(HDR_BAD, 2'b11);
        @(posedge rx_clk); #1;
        tests++;
        if (gt_if.rxgearboxslip !== 1'b1) begin
            fails++;
            $display("FAIL arst_pre_slip: slip=%b want 1", gt_if.rxgearboxslip);
        end
        rx_rst_n = 1'b0;
        #1;
        tests++;
        if (gt_if.rxgearboxslip !== 1'b0 || slip_cnt !== 4'd0) begin
            fails++;
            $display("FAIL arst_in_slip: slip=%b slip_cnt=%0d want 0/0",
                     gt_if.rxgearboxslip, slip_cnt);
        end
        // Now reset deep in SLIP_WAIT (wait_cnt=10 after edge 12).
        do_reset(HDR_BAD, 2'b11);
        repeat (12) @(posedge rx_clk);
        #1 rx_rst_n = 1'b0;
        #1;
        tests++;
        if ({gt_if.rxgearboxslip, gt_if.block_lock, slip_cnt, lock_loss_cnt} !== '0) begin
            fails++;
            $display("FAIL arst_wait: slip=%b lock=%b slip_cnt=%0d loss=%0d want 0",
                     gt_if.rxgearboxslip, gt_if.block_lock, slip_cnt, lock_loss_cnt);
        end
        gt_if.rxheader = HDR_GOOD;
        @(posedge rx_clk);
        #1 rx_rst_n = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(posedge rx_clk); #1;
            tests++;
            if (gt_if.block_lock !== (n == 32) || gt_if.rxgearboxslip !== 1'b0) begin
                fails++;
                $display("FAIL arst_relock cyc%0d: lock=%b slip=%b", n,
                         gt_if.block_lock, gt_if.rxgearboxslip);
            end
        end
    endtask

    task automatic test_enable();
        do_reset(HDR_BAD, 2'b11);
        @(posedge rx_clk); #1;
        cfg_enable = 1'b0;  // drop mid-pulse: pulse must not extend
        for (int n = 2; n <= 45; n++) begin
            @(posedge rx_clk); #1;
            tests++;
            if (gt_if.rxgearboxslip !== 1'b0 || gt_if.block_lock !== 1'b0) begin
                fails++;
                $display("FAIL en_off cyc%0d: slip=%b lock=%b want 0/0", n,
                         gt_if.rxgearboxslip, gt_if.block_lock);
            end
        end
        tests++;
        if (slip_cnt !== 4'd1) begin
            fails++;
            $display("FAIL en_slip_cnt: got %0d want 1", slip_cnt);
        end
        cfg_enable = 1'b1;
        gt_if.rxheader = HDR_GOOD;
        repeat (32) @(posedge rx_clk);
        #1;
        tests++;
        if (gt_if.block_lock !== 1'b1) begin
            fails++;
            $display("FAIL en_relock: lock=%b want 1", gt_if.block_lock);
        end
        cfg_enable = 1'b0;
        @(posedge rx_clk); #1;
        tests++;
        if (gt_if.block_lock !== 1'b0) begin
            fails++;
            $display("FAIL en_clear_lock: lock=%b want 0", gt_if.block_lock);
        end
    endtask

    task automatic test_saturate_clr();
        do_reset(HDR_BAD, 2'b11);
        // Slips land on edges 1+34k; 15 saturates a 4-bit counter by edge 477.
        for (int n = 1; n <= 613; n++) begin
            @(posedge rx_clk); #1;
            if (n == 550) begin
                tests++;
                if (slip_cnt !== 4'hF) begin
                    fails++;
                    $display("FAIL sat_hold: slip_cnt=%0d want 15", slip_cnt);
                end
            end
            if (n == 578) clr_cnt = 1'b1;
            if (n == 579) begin
                clr_cnt = 1'b0;
                tests++;
                if (gt_if.rxgearboxslip !== 1'b1 || slip_cnt !== 4'd0) begin
                    fails++;
                    $display("FAIL clr_on_slip: slip=%b slip_cnt=%0d want 1/0",
                             gt_if.rxgearboxslip, slip_cnt);
                end
            end
            if (n == 613) begin
                tests++;
                if (slip_cnt !== 4'd1) begin
                    fails++;
                    $display("FAIL post_clr_inc: slip_cnt=%0d want 1", slip_cnt);
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_lock_good();
        test_slip_period();
        test_invalid_threshold();
        test_alt_valid();
        test_async_reset();
        test_enable();
        test_saturate_clr();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
